posit_encode_pipe: RTL
======================

# posit_encode_pipe

Pipelined posit encoder: converts a decoded `value_sum` result (sign, scale, guard-extended fraction, inf/zero flags) back into an NBITS-wide posit word with regime/exponent packing, round-to-nearest-even and saturation. It sits at the tail of the posit adder and accumulator datapath, the write side of the stream whose read side unpacks posits into `posit_defines` value structs. It has valid/ready flow control on both ends and a fixed three-stage latency.

## Interface

- NBITS, 32, posit width (from `posit_defines`)
- ES, 2, exponent field width
- ABITS, FBITS+4, input fraction width: hidden bit, FBITS fraction bits, guard, round, sticky (MSB to LSB)
- clk  in  1  clock; all state is updated on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  stage 1 accepts this cycle
- in_sign  in  1  sign
- in_scale  in  8  signed scale, 2^scale
- in_fraction  in  ABITS  normalized fraction; hidden bit set unless zero/inf
- in_inf  in  1  NaR input
- in_zero  in  1  zero input
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  NBITS  encoded posit
- out_nar  out  1  out_data is NaR (0x80000000)

## Operation

- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- Global stall: `advance = !out_valid || out_ready`. `in_ready = advance`. All three stage registers load only when `advance` is 1. Bubbles (valid=0) shift through the pipeline like data.
- Stage 1 registers the inputs and computes the following:
  - `k = scale >>> ES` (arithmetic shift) and `e = scale[ES-1:0]`.
  - Saturation flags: `hi = scale >= (NBITS-2)<<ES` (120) and `lo = scale <= -((NBITS-2)<<ES)` (-120).
- Stage 2 builds the unsigned magnitude string:
  - Regime: k+1 ones then a 0 if k ≥ 0; otherwise -k zeros then a 1.
  - Then the ES bits of e, then fraction bits below the hidden bit.
  - The string is right-shifted into NBITS-1 bits. Stage 2 registers the kept bits plus `lsb`, `guard` (first dropped bit) and `sticky` (OR of all remaining dropped bits, including input R/S).
- Stage 3 rounds and registers the output:
  - RNE: add 1 when `guard && (lsb || sticky)`.
  - If the rounded magnitude overflows to 0 in the NBITS-1 bits, clamp it to maxpos (all ones).
  - If the magnitude is 0 for a nonzero input, force it to minpos (1).
  - If sign is set, out_data is the two's complement of `{1'b0, mag}`.
- Priority, highest first:
  1. inf: out_data = 0x80000000, out_nar = 1.
  2. zero: out_data = 0.
  3. hi: magnitude = 0x7FFFFFFF.
  4. lo: magnitude = 0x00000001.
  5. Normal encode.
- Sign is applied after saturation. Posits never round to zero or to NaR.

## Timing

- Latency: 3 cycles from input transfer to out_valid when not stalled. Throughput is 1 word per cycle.
- Reset values: out_valid = 0, out_data = 0, out_nar = 0, all internal valids = 0. in_ready = 1 after reset, because out_valid = 0.
- Reset asserted mid-operation discards all in-flight words. No output transfer occurs on the reset cycle or after it until new inputs arrive.
- While stalled (`out_valid && !out_ready`), out_data and out_nar hold stable and in_ready = 0.
- Simultaneous output transfer and input transfer in the same cycle is legal and loses no word.
- in_* values are sampled only on an input transfer; they are don't-care otherwise.

## Configuration

- `POSIT_ENC_RNE_EN` defined: stage 3 applies round-to-nearest-even as described.
- `POSIT_ENC_RNE_EN` undefined: truncation only.
  - guard and sticky are not computed and the increment adder is removed.
  - Saturation and minpos forcing remain.
  - Latency stays at 3 cycles.

## Test plan

1. 1.0: scale 0, fraction = hidden only, sign 0 -> 0x40000000 three cycles later. With sign 1 -> 0xC0000000.
2. Packing: scale 1 -> 0x48000000; scale 4 -> 0x60000000; scale -1 -> 0x38000000.
3. Rounding (RNE build):
   - Scale 0, fraction LSB 0, guard 1, round 0, sticky 0 -> 0x40000000 (tie to even).
   - Same with fraction LSB 1 -> 0x40000002.
   - Truncation build gives 0x40000000 and 0x40000001.
4. Saturation and flags:
   - scale 127 -> 0x7FFFFFFF.
   - scale -128 -> 0x00000001.
   - Same with sign 1 -> 0x80000001 and 0xFFFFFFFF.
   - in_inf -> 0x80000000 with out_nar = 1.
   - in_zero -> 0x00000000.
5. Backpressure: stream 10 words back-to-back with out_ready toggled randomly -> all 10 outputs appear in order, none lost or duplicated, and out_data is stable while stalled.
6. Reset mid-stream: assert reset for 1 cycle with 3 words in flight -> out_valid = 0 on the next cycle and none of the 3 words ever appears.

Source files
------------

// File: rtl/posit_encode_pipe.sv
// ---------------------------------------------------------------------------
// posit_encode_pipe
//
// Three-stage pipelined posit encoder. Takes a decoded value (sign, signed
// scale, hidden-bit-normalized fraction with guard/round/sticky tail and
// NaR/zero flags) and packs it into an NBITS-wide posit word: regime run,
// ES exponent bits, fraction bits, then rounding and saturation.
//
//   stage 1 : register inputs, split scale into regime k / exponent e,
//             detect saturation (|scale| too large for any regime)
//   stage 2 : build the regime/exponent/fraction bit string and cut it to
//             NBITS-1 magnitude bits plus guard / sticky
//   stage 3 : round, clamp (never to zero, never to NaR), apply sign
//
// Optional build macro:
//   POSIT_ENC_RNE_EN  defined   -> round-to-nearest-even in stage 3
//                     undefined -> truncation only (no guard/sticky/adder)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high; flushes all in-flight words
//   in_valid     input word present
//   in_ready     stage 1 accepts this cycle (= pipeline advances)
//   in_sign      sign of the value
//   in_scale     signed scale, value = 2^scale * 1.fraction
//   in_fraction  {hidden, FBITS fraction bits, guard, round, sticky}
//   in_inf       NaR input
//   in_zero      zero input
//   out_valid    out_data holds an encoded word
//   out_ready    downstream accepts out_data
//   out_data     encoded posit
//   out_nar      out_data is NaR
// ---------------------------------------------------------------------------
module posit_encode_pipe #(
    parameter int NBITS = 32,
    parameter int ES    = 2,
    parameter int FBITS = NBITS - 3 - ES,
    parameter int ABITS = FBITS + 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [7:0]       in_scale,
    input  logic [ABITS-1:0] in_fraction,
    input  logic             in_inf,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_data,
    output logic             out_nar
);

    // Magnitude width (everything but the sign bit).
    localparam int MW    = NBITS - 1;
    // Bits following the regime: exponent plus fraction below the hidden bit.
    localparam int TW    = ES + ABITS - 1;
    // Bit-string width: 2-bit regime seed, tail, and NBITS of headroom so the
    // longest regime shift never pushes tail bits off the bottom.
    localparam int STR_W = 2 + TW + NBITS;

    // Beyond these scales even the longest regime cannot represent the value.
    localparam logic signed [7:0] SAT_POS = 8'((NBITS - 2) << ES);
    localparam logic signed [7:0] SAT_NEG = -SAT_POS;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic advance_s;
    logic out_valid_r;
    logic [NBITS-1:0] out_data_r;
    logic out_nar_r;

    assign advance_s = ~out_valid_r | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_nar   = out_nar_r;

    // ------------------------------------------------------------------
    // Stage 1: regime / exponent split and saturation detect
    // ------------------------------------------------------------------
    logic signed [7:0] scale_s;
    logic [7:0]        k_s;
    logic              regime_pos_s;
    logic [7:0]        shift_s;
    logic              hi_s;
    logic              lo_s;

    assign scale_s      = $signed(in_scale);
    assign k_s          = scale_s >>> ES;
    assign regime_pos_s = ~in_scale[7];
    // k >= 0 : run of k+1 ones, seed already holds one -> shift by k.
    // k <  0 : run of -k zeros, seed already holds one -> shift by -k-1 = ~k.
    assign shift_s      = regime_pos_s ? k_s : ~k_s;
    assign hi_s         = (scale_s >= SAT_POS);
    assign lo_s         = (scale_s <= SAT_NEG);

    logic             s1_valid_r;
    logic             s1_sign_r;
    logic             s1_inf_r;
    logic             s1_zero_r;
    logic             s1_hi_r;
    logic             s1_lo_r;
    logic             s1_pos_r;
    logic [7:0]       s1_shift_r;
    logic [ES-1:0]    s1_exp_r;
    logic [ABITS-2:0] s1_frac_r;

    // Stage 1 register: capture the input word and its regime parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_inf_r   <= 1'b0;
            s1_zero_r  <= 1'b0;
            s1_hi_r    <= 1'b0;
            s1_lo_r    <= 1'b0;
            s1_pos_r   <= 1'b0;
            s1_shift_r <= 8'd0;
            s1_exp_r   <= {ES{1'b0}};
            s1_frac_r  <= {(ABITS-1){1'b0}};
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            s1_sign_r  <= in_sign;
            s1_inf_r   <= in_inf;
            s1_zero_r  <= in_zero;
            s1_hi_r    <= hi_s;
            s1_lo_r    <= lo_s;
            s1_pos_r   <= regime_pos_s;
            s1_shift_r <= shift_s;
            s1_exp_r   <= in_scale[ES-1:0];
            s1_frac_r  <= in_fraction[ABITS-2:0];
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: bit-string construction
    // ------------------------------------------------------------------
    logic [TW-1:0]    tail_s;
    logic [STR_W-1:0] seed_s;
    logic [STR_W-1:0] str_s;

    // Place the regime seed and tail at the top and shift the run in. For
    // positive regimes the run is ones, so shift the complement and invert.
    always_comb begin
        tail_s = {s1_exp_r, s1_frac_r};
        if (s1_pos_r) begin
            seed_s = {2'b10, tail_s, {NBITS{1'b0}}};
            str_s  = ~((~seed_s) >> s1_shift_r);
        end else begin
            seed_s = {2'b01, tail_s, {NBITS{1'b0}}};
            str_s  = seed_s >> s1_shift_r;
        end
    end

    logic [MW-1:0] kept_s;
    assign kept_s = str_s[STR_W-1 -: MW];

`ifdef POSIT_ENC_RNE_EN
    logic guard_s;
    logic sticky_s;
    assign guard_s  = str_s[STR_W-MW-1];
    // Covers the dropped fraction bits as well as the incoming R/S bits.
    assign sticky_s = |str_s[STR_W-MW-2:0];
`endif

    logic          s2_valid_r;
    logic          s2_sign_r;
    logic          s2_inf_r;
    logic          s2_zero_r;
    logic          s2_hi_r;
    logic          s2_lo_r;
    logic [MW-1:0] s2_kept_r;
`ifdef POSIT_ENC_RNE_EN
    logic          s2_guard_r;
    logic          s2_sticky_r;
`endif

    // Stage 2 register: truncated magnitude plus rounding information.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r  <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_inf_r    <= 1'b0;
            s2_zero_r   <= 1'b0;
            s2_hi_r     <= 1'b0;
            s2_lo_r     <= 1'b0;
            s2_kept_r   <= {MW{1'b0}};
`ifdef POSIT_ENC_RNE_EN
            s2_guard_r  <= 1'b0;
            s2_sticky_r <= 1'b0;
`endif
        end else if (advance_s) begin
            s2_valid_r  <= s1_valid_r;
            s2_sign_r   <= s1_sign_r;
            s2_inf_r    <= s1_inf_r;
            s2_zero_r   <= s1_zero_r;
            s2_hi_r     <= s1_hi_r;
            s2_lo_r     <= s1_lo_r;
            s2_kept_r   <= kept_s;
`ifdef POSIT_ENC_RNE_EN
            s2_guard_r  <= guard_s;
            s2_sticky_r <= sticky_s;
`endif
        end else begin
            s2_valid_r  <= s2_valid_r;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: rounding, clamping, sign
    // ------------------------------------------------------------------
    logic [MW:0]      sum_s;
    logic             round_up_s;
    logic [MW-1:0]    norm_mag_s;
    logic [MW-1:0]    sat_mag_s;
    logic [NBITS-1:0] data_nxt_s;
    logic             nar_nxt_s;

    // Round the kept bits, keep the result inside (0, maxpos], then pick the
    // special-case encodings by priority and apply the sign last.
    always_comb begin
`ifdef POSIT_ENC_RNE_EN
        round_up_s = s2_guard_r & (s2_kept_r[0] | s2_sticky_r);
`else
        round_up_s = 1'b0;
`endif
        sum_s = {1'b0, s2_kept_r} + {{MW{1'b0}}, round_up_s};

        if (sum_s[MW]) begin
            norm_mag_s = {MW{1'b1}};
        end else if (sum_s[MW-1:0] == {MW{1'b0}}) begin
            norm_mag_s = {{(MW-1){1'b0}}, 1'b1};
        end else begin
            norm_mag_s = sum_s[MW-1:0];
        end

        if (s2_hi_r) begin
            sat_mag_s = {MW{1'b1}};
        end else if (s2_lo_r) begin
            sat_mag_s = {{(MW-1){1'b0}}, 1'b1};
        end else begin
            sat_mag_s = norm_mag_s;
        end

        if (s2_inf_r) begin
            data_nxt_s = {1'b1, {MW{1'b0}}};
            nar_nxt_s  = 1'b1;
        end else if (s2_zero_r) begin
            data_nxt_s = {NBITS{1'b0}};
            nar_nxt_s  = 1'b0;
        end else if (s2_sign_r) begin
            data_nxt_s = (~{1'b0, sat_mag_s}) + {{(NBITS-1){1'b0}}, 1'b1};
            nar_nxt_s  = 1'b0;
        end else begin
            data_nxt_s = {1'b0, sat_mag_s};
            nar_nxt_s  = 1'b0;
        end
    end

    // Output register: holds steady while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {NBITS{1'b0}};
            out_nar_r   <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= s2_valid_r;
            out_data_r  <= data_nxt_s;
            out_nar_r   <= nar_nxt_s;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // The hidden bit is implied by the encoding; in the truncating build the
    // bits below the kept magnitude are trimmed away by synthesis.
    logic unused_s;
`ifdef POSIT_ENC_RNE_EN
    assign unused_s = in_fraction[ABITS-1];
`else
    assign unused_s = ^{in_fraction[ABITS-1], str_s[STR_W-MW-1:0]};
`endif

endmodule
